// File: rtl/ifetch_pq_pkg.sv
// Shared definitions for the bexkat1 prefetching instruction fetch unit.
package bexkat1Def;

  // Bus-side fetch sequencer states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } ifetch_state_t;

  // Bit of the first instruction word that marks a 64-bit (long) instruction.
  localparam int IR_LONG_BIT = 0;

endpackage

// File: rtl/ifetch_pq_queue.sv
// ifetch_queue: DEPTH-entry word FIFO for the prefetcher.
// Pushes one word, pops one or two, and flushes synchronously.
// Exposes the two head entries and the occupancy count.
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic [1:0]                 pop_n,
  output logic [31:0]                head0,
  output logic [31:0]                head1,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);
    end
  end

  // Word storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; count gates every read, so stale
    // contents are never observed.
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_pq.sv
// ifetch_pq: prefetching instruction fetch unit for the bexkat1 pipeline.
// Streams sequential words into a prefetch queue, assembles 32/64-bit
// instructions for decode, and handles pc_set redirects (flush + drain).
// Optional macro IFETCH_ALIGN_EXC_EN adds exc_misalign for unaligned redirects.
module ifetch_pq
  import bexkat1Def::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        bus_cyc,
  output logic [31:0] bus_adr,
  input  logic        bus_ack,
  input  logic [31:0] bus_in,
  input  logic        pc_set,
  input  logic [31:0] pc_in,
  input  logic        stall_i,
  output logic [63:0] ir,
  output logic        ir_valid,
`ifdef IFETCH_ALIGN_EXC_EN
  output logic        exc_misalign,
`endif
  output logic [31:0] pc
);

  localparam int             CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  ifetch_state_t state, state_nxt;
  logic [31:0]   fa, fa_nxt;
  logic [31:0]   fa_pending, fa_pending_nxt;
  logic [31:0]   head0, head1;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   pc_tgt;
  logic          head_long;
  logic          consume;
  logic          push;
  logic [1:0]    pop_n;
  logic          exc_nxt;

`ifdef IFETCH_ALIGN_EXC_EN
  assign pc_tgt  = pc_in;
  assign exc_nxt = pc_set ? (pc_in[1:0] != 2'b00) : exc_misalign;
`else
  assign pc_tgt  = pc_in & ~32'h3;
  assign exc_nxt = 1'b0;
`endif

  assign bus_adr   = fa;
  assign head_long = head0[IR_LONG_BIT];
  assign ir_valid  = (count != '0 && !head_long) || (count >= CW'(2) && head_long);
  assign ir        = !ir_valid ? 64'h0 : head_long ? {head1, head0} : {32'h0, head0};
  assign consume   = ir_valid && !stall_i && !pc_set;
  assign pop_n     = !consume ? 2'd0 : head_long ? 2'd2 : 2'd1;
  assign push      = (state == S_FETCH) && bus_ack && !pc_set;
  assign count_nxt = count + CW'(push) - CW'(pop_n);

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (pc_set),
    .push      (push),
    .push_data (bus_in),
    .pop_n     (pop_n),
    .head0     (head0),
    .head1     (head1),
    .count     (count)
  );

  // Next-state and fetch-address logic for the bus sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt      = state;
    fa_nxt         = fa;
    fa_pending_nxt = fa_pending;
    case (state)
      S_IDLE: begin
        if (pc_set) begin
          fa_nxt = pc_tgt;
          if (!exc_nxt) state_nxt = S_FETCH;
        end else if (count < DEPTH_C && !exc_nxt) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (pc_set && bus_ack) begin
          fa_nxt    = pc_tgt;
          state_nxt = exc_nxt ? S_IDLE : S_FETCH;
        end else if (pc_set) begin
          fa_pending_nxt = pc_tgt;
          state_nxt      = S_DRAIN;
        end else if (bus_ack) begin
          fa_nxt = fa + 32'd4;
          if (count_nxt >= DEPTH_C) state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (pc_set) fa_pending_nxt = pc_tgt;
        if (bus_ack) begin
          fa_nxt    = pc_set ? pc_tgt : fa_pending;
          state_nxt = exc_nxt ? S_IDLE : S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, registered bus request and fetch addresses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      bus_cyc    <= 1'b0;
      fa         <= RESET_PC;
      fa_pending <= RESET_PC;
    end else begin
      state      <= state_nxt;
      bus_cyc    <= (state_nxt != S_IDLE);
      fa         <= fa_nxt;
      fa_pending <= fa_pending_nxt;
    end
  end

  // Program counter of the head instruction; redirects win over consumes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        pc <= RESET_PC;
    else if (pc_set)  pc <= pc_tgt;
    else if (consume) pc <= pc + (head_long ? 32'd8 : 32'd4);
  end

`ifdef IFETCH_ALIGN_EXC_EN
  // Misaligned-redirect flag, cleared by the next aligned redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) exc_misalign <= 1'b0;
    else       exc_misalign <= exc_nxt;
  end
`endif

endmodule

// File: tb/tb_ifetch_pq.sv
// Self-checking bench for ifetch_pq: directed latency/redirect scenarios,
// then randomized stall/wait/redirect traffic against an instruction-stream model.
module tb_ifetch_pq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        bus_cyc;
  logic [31:0] bus_adr;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_in = 32'h0;
  logic        pc_set = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        stall_i = 1'b0;
  logic [63:0] ir;
  logic        ir_valid;
  logic [31:0] pc;
`ifdef IFETCH_ALIGN_EXC_EN
  logic        exc_misalign;
`endif

  ifetch_pq #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus_cyc  (bus_cyc),
    .bus_adr  (bus_adr),
    .bus_ack  (bus_ack),
    .bus_in   (bus_in),
    .pc_set   (pc_set),
    .pc_in    (pc_in),
    .stall_i  (stall_i),
    .ir       (ir),
    .ir_valid (ir_valid),
`ifdef IFETCH_ALIGN_EXC_EN
    .exc_misalign (exc_misalign),
`endif
    .pc       (pc)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction memory: a small table for directed tests, a hash for random.
  logic [31:0] dmem [256];
  bit          use_hash = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (use_hash) begin
      h = (a ^ (a >> 9)) * 32'h9E3779B1;
      return h ^ (h >> 15);
    end
    return dmem[a[9:2]];
  endfunction

  // Bus slave: answers each request after 0..max_wait wait states.
  bit ack_hold  = 1'b0;
  int max_wait  = 0;
  int wait_left = 0;

  initial forever begin
    @(posedge clk_i);
    #2;
    if (rst_i || !bus_cyc || ack_hold) begin
      bus_ack = 1'b0;
    end else if (wait_left > 0) begin
      wait_left--;
      bus_ack = 1'b0;
    end else begin
      bus_ack   = 1'b1;
      bus_in    = mem_word(bus_adr);
      wait_left = $urandom_range(max_wait, 0);
    end
  end

  // Reference model: the instruction stream that must leave the unit is
  // fully determined by memory contents and the latest redirect target.
  logic [31:0] exp_pc = 32'h0;
  int          idle = 0;

  always @(negedge clk_i) begin
    logic [31:0] w0;
    logic [63:0] exp_ir;
    if (rst_i) begin
      exp_pc = 32'h0;
      idle   = 0;
    end else begin
      if (!ir_valid) check("ir_zero", ir, 64'h0);
      if (pc_set) begin
`ifdef IFETCH_ALIGN_EXC_EN
        exp_pc = pc_in;
`else
        exp_pc = pc_in & ~32'h3;
`endif
      end else if (ir_valid && !stall_i) begin
        w0     = mem_word(exp_pc);
        exp_ir = w0[0] ? {mem_word(exp_pc + 32'd4), w0} : {32'h0, w0};
        check("ir", ir, exp_ir);
        check("pc", {32'h0, pc}, {32'h0, exp_pc});
        exp_pc = exp_pc + (w0[0] ? 32'd8 : 32'd4);
      end
      idle = (ir_valid || stall_i || pc_set) ? 0 : idle + 1;
      if (idle > 64) begin
        check("progress_idle_cycles", 64'(idle), 64'd0);
        idle = 0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old_adr;
    for (int i = 0; i < 256; i++) dmem[i] = 32'(i) << 8;
    dmem[0] = 32'h10;
    dmem[1] = 32'h20;
    dmem[2] = 32'h30;
    dmem[3] = 32'h00000001;
    dmem[4] = 32'hCAFEF00D;

    // Reset state.
    #1 rst_i = 1'b1;
    #2;
    check("rst_bus_cyc", bus_cyc, 1'b0);
    check("rst_bus_adr", bus_adr, 32'h0);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_ir", ir, 64'h0);
    check("rst_pc", pc, 32'h0);
    step(3);
    rst_i = 1'b0;

    // First request and zero-wait short/long stream.
    step();
    check("first_cyc", bus_cyc, 1'b1);
    check("first_adr", bus_adr, 32'h0);
    check("first_valid", ir_valid, 1'b0);
    step();
    check("s0_valid", ir_valid, 1'b1);
    check("s0_ir", ir, 64'h10);
    check("s0_pc", pc, 32'h0);
    check("s0_adr", bus_adr, 32'h4);
    step();
    check("s1_ir", ir, 64'h20);
    check("s1_pc", pc, 32'h4);
    check("s1_adr", bus_adr, 32'h8);
    step();
    check("s2_ir", ir, 64'h30);
    check("s2_pc", pc, 32'h8);
    step();
    check("long_half_valid", ir_valid, 1'b0);
    step();
    check("long_ir", ir, 64'hCAFEF00D_00000001);
    check("long_pc", pc, 32'hC);
    step();
    check("after_long_pc", pc, 32'h14);
    check("after_long_ir", ir, 64'h500);

    // Stall fills the queue; release resumes fetching after the 4 words.
    stall_i = 1'b1;
    pc_set  = 1'b1;
    pc_in   = 32'h40;
    step();
    pc_set = 1'b0;
    step(12);
    check("full_cyc", bus_cyc, 1'b0);
    check("full_adr", bus_adr, 32'h50);
    check("full_pc", pc, 32'h40);
    check("full_ir", ir, 64'h1000);
    stall_i = 1'b0;
    for (int k = 0; k < 4 && !bus_cyc; k++) step();
    check("resume_cyc", bus_cyc, 1'b1);
    check("resume_adr", bus_adr, 32'h50);
    step(3);

    // Redirect while a request is outstanding without ack.
    stall_i  = 1'b1;
    ack_hold = 1'b1;
    step(2);
    check("drain_pre_cyc", bus_cyc, 1'b1);
    old_adr = bus_adr;
    dmem[old_adr[9:2]] = 32'hDEAD;
    pc_set = 1'b1;
    pc_in  = 32'h100;
    step();
    pc_set = 1'b0;
    check("drain_adr", bus_adr, old_adr);
    check("drain_cyc", bus_cyc, 1'b1);
    check("drain_valid0", ir_valid, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("drain_valid", ir_valid, 1'b0);
    end
    ack_hold = 1'b0;
    stall_i  = 1'b0;
    step();
    check("drain_done_adr", bus_adr, 32'h100);
    check("drain_done_cyc", bus_cyc, 1'b1);
    check("drain_done_valid", ir_valid, 1'b0);
    step(6);

    // Redirect, ack and consume in the same cycle.
    check("sc_pre_valid", ir_valid, 1'b1);
    check("sc_pre_cyc", bus_cyc, 1'b1);
    pc_set = 1'b1;
    pc_in  = 32'h200;
    step();
    pc_set = 1'b0;
    check("sc_pc", pc, 32'h200);
    check("sc_valid", ir_valid, 1'b0);
    check("sc_adr", bus_adr, 32'h200);
    step(4);

    // Randomized traffic from the hashed memory, starting at the wrap point.
    use_hash = 1'b1;
    max_wait = 3;
    pc_set   = 1'b1;
    pc_in    = 32'hFFFF_FFF0;
    step();
    for (int c = 0; c < 3000; c++) begin
      stall_i = ($urandom_range(3, 0) == 0);
      if ($urandom_range(39, 0) == 0) begin
        pc_set = 1'b1;
        pc_in  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(7, 0))) : $urandom;
`ifdef IFETCH_ALIGN_EXC_EN
        pc_in[1:0] = 2'b00;
`endif
      end else begin
        pc_set = 1'b0;
      end
      step();
    end
    stall_i = 1'b0;
    pc_set  = 1'b0;
    step(20);

`ifdef IFETCH_ALIGN_EXC_EN
    max_wait = 0;
    pc_set   = 1'b1;
    pc_in    = 32'h102;
    step();
    pc_set = 1'b0;
    check("exc_set", exc_misalign, 1'b1);
    check("exc_pc", pc, 32'h102);
    step(6);
    check("exc_hold", exc_misalign, 1'b1);
    check("exc_no_fetch", bus_cyc, 1'b0);
    check("exc_valid", ir_valid, 1'b0);
    pc_set = 1'b1;
    pc_in  = 32'h104;
    step();
    pc_set = 1'b0;
    check("exc_clear", exc_misalign, 1'b0);
    check("exc_refetch_cyc", bus_cyc, 1'b1);
    check("exc_refetch_adr", bus_adr, 32'h104);
    step(10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
